vga_scanout: RTL and testbench

- Downstream consumer of the video RAM that the RISC-V core writes through the memory bus.
- Generates 640x480@60 Hz VGA timing from CLOCK_50.
- Fetches a 160x120 RGB332 framebuffer (4x pixel replication) from a synchronous 32-bit read port.
- Drives the board DAC pins and gives the CPU a vertical-blank status and a frame-start pulse.

---
 rtl/vga_scanout.sv | 213 +++++++++++++++++++++
 tb/tb_vga_scanout.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// -----------------------------------------------------------------------------
// vga_scanout
//
// Scans a 160x120 RGB332 framebuffer out of video RAM as 640x480@60 Hz VGA.
// Every framebuffer pixel is replicated 4x horizontally and 4x vertically.
// One pixel spans two CLOCK_50 cycles:
//   phase 0 : the address of the current pixel is presented on vaddr/vbyte
//   phase 1 : (the pixel tick) the RAM word returns on vdata. The selected
//             byte is expanded and loaded into the pin register, and the
//             counters advance.
// Because the pin register is loaded on the tick, every pin output lags the
// counters by exactly one pixel. Colour, blank and syncs therefore stay
// aligned with each other.
//
// Ports
//   CLOCK_50        50 MHz system clock
//   reset_n         asynchronous active-low reset
//   vaddr   [12:0]  video RAM word address of the pixel being fetched
//   vdata   [31:0]  RAM read data, valid one CLOCK_50 cycle after vaddr
//   vbyte   [1:0]   byte lane (little-endian) of that pixel inside the word
//   VGA_R/G/B [7:0] colour channels, forced to 0 outside the visible area
//   VGA_HS, VGA_VS  syncs, active low
//   VGA_BLANK_N     high while the registered pixel is visible
//   VGA_SYNC_N      tied low
//   VGA_CLK         25 MHz pixel clock; rises in the middle of each pixel
//   vblank          high while the registered line is at or below V_VISIBLE
//   frame_start     one-cycle pulse after pixel (0,0) has been registered
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module vga_scanout #(
  parameter int          H_VISIBLE = 640,
  parameter int          H_FRONT   = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BACK    = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FRONT   = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BACK    = 33,
  parameter logic [12:0] BASE_ADDR = 13'd0
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  output logic [12:0] vaddr,
  input  logic [31:0] vdata,
  output logic [1:0]  vbyte,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        VGA_CLK,
  output logic        vblank,
  output logic        frame_start
);

  // ---------------------------------------------------------------------------
  // Timing constants. Both counters are 10 bits wide. That covers 800 columns
  // and 525 lines.
  // ---------------------------------------------------------------------------
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // Everything that reaches the board pins goes through one register, so all
  // of these outputs share the same latency.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic       vblank;
  } pins_t;

  localparam pins_t PINS_RESET = '{
    r: 8'h00, g: 8'h00, b: 8'h00,
    hs: 1'b1, vs: 1'b1, blank_n: 1'b0, vblank: 1'b0
  };

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic       phase_q,       phase_d;
  logic       vga_clk_q,     vga_clk_d;
  logic [9:0] hcount_q,      hcount_d;
  logic [9:0] vcount_q,      vcount_d;
  pins_t      pins_q,        pins_d;
  logic       frame_start_q, frame_start_d;

  logic        tick;
  logic [7:0]  fb_x;
  logic [7:0]  fb_y;
  logic [14:0] fb_idx;
  logic [7:0]  pix;
  logic        visible;

  // The pixel tick is the second CLOCK_50 cycle of every pixel.
  assign tick = phase_q;

  // ---------------------------------------------------------------------------
  // Phase and raster counters
  // ---------------------------------------------------------------------------
  always_comb begin : timing_next
    // NOTE: every signal driven here gets a default first. A path that leaves
    // one unassigned would infer a latch.
    phase_d   = ~phase_q;
    // The register takes the next value of phase, so VGA_CLK always equals
    // phase. It falls on the tick and rises halfway through the pixel.
    vga_clk_d = ~phase_q;
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;

    if (tick) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch address. The counters stay stable for the whole pixel, so this
  // address is held through phase 0. The RAM registers it at the end of
  // phase 0 and returns the word during phase 1, in time for the tick.
  // idx = y*160 + x, written as shifts and adds so that no multiplier is
  // built. The result keeps following the raster during blanking. The data
  // fetched there is simply ignored.
  // ---------------------------------------------------------------------------
  always_comb begin : fetch_addr
    fb_x   = hcount_q[9:2];
    fb_y   = vcount_q[9:2];
    fb_idx = {fb_y, 7'b000_0000} + {2'b00, fb_y, 5'b0_0000} + {7'b000_0000, fb_x};
    vaddr  = BASE_ADDR + fb_idx[14:2];
    vbyte  = fb_idx[1:0];
  end

  // ---------------------------------------------------------------------------
  // Byte select, RGB332 expansion, sync decode
  // ---------------------------------------------------------------------------
  always_comb begin : pins_next
    pix           = vdata[{vbyte, 3'b000} +: 8];
    visible       = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    pins_d        = pins_q;
    frame_start_d = 1'b0;

    if (tick) begin
      // Repeating the top bits makes full scale reach exactly 8'hFF and zero
      // reach exactly 8'h00.
      pins_d.r       = visible ? {pix[7:5], pix[7:5], pix[7:6]}             : 8'h00;
      pins_d.g       = visible ? {pix[4:2], pix[4:2], pix[4:3]}             : 8'h00;
      pins_d.b       = visible ? {pix[1:0], pix[1:0], pix[1:0], pix[1:0]}   : 8'h00;
      pins_d.blank_n = visible;
      pins_d.hs      = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
      pins_d.vs      = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));
      pins_d.vblank  = (vcount_q >= V_VIS);
      // This pulses in the cycle right after (0,0) has been registered on the
      // pins. On the next cycle it is not a tick, so the pulse clears.
      frame_start_d  = (hcount_q == '0) && (vcount_q == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers. A reset restarts the raster at (0,0) with the pins idle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      phase_q       <= 1'b0;
      vga_clk_q     <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      pins_q        <= PINS_RESET;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All registers
      // then update together from values sampled at the same edge.
      phase_q       <= phase_d;
      vga_clk_q     <= vga_clk_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      pins_q        <= pins_d;
      frame_start_q <= frame_start_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign VGA_R       = pins_q.r;
  assign VGA_G       = pins_q.g;
  assign VGA_B       = pins_q.b;
  assign VGA_HS      = pins_q.hs;
  assign VGA_VS      = pins_q.vs;
  assign VGA_BLANK_N = pins_q.blank_n;
  assign vblank      = pins_q.vblank;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = vga_clk_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// -----------------------------------------------------------------------------
// tb_vga_scanout
//
// There are two instances of the design, both on the same clock and reset:
//   dut_s : reduced raster, 60x32 total (40x24 visible), BASE_ADDR = 0.
//           It is fully checked on every cycle over two frames and again
//           after a reset mid-frame.
//   dut_d : default 800x525 raster, BASE_ADDR = 1000. It is checked for
//           addressing and horizontal timing over its first few lines.
// Each instance reads its own port of a shared RAM. The RAM has one cycle of
// latency. The expected values come from the cycle count since reset
// release, using direct arithmetic. In addition there are hand-computed
// points and totals.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vga_scanout;

  // Reduced raster for dut_s
  localparam int SH_VIS = 40, SH_FP = 4, SH_SY = 8, SH_BP = 8, SH_TOT = 60;
  localparam int SV_VIS = 24, SV_FP = 2, SV_SY = 2, SV_BP = 4, SV_TOT = 32;
  localparam int S_FRAME = SH_TOT * SV_TOT;   // 1920 pixels

  logic        CLOCK_50;
  logic        reset_n;

  logic [12:0] vaddr_s,  vaddr_d;
  logic [31:0] vdata_s,  vdata_d;
  logic [1:0]  vbyte_s,  vbyte_d;
  logic [7:0]  r_s, g_s, b_s, r_d, g_d, b_d;
  logic        hs_s, vs_s, blank_n_s, sync_n_s, vga_clk_s, vblank_s, fs_s;
  logic        hs_d, vs_d, blank_n_d, sync_n_d, vga_clk_d, vblank_d, fs_d;

  logic [31:0] mem [0:8191];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  vga_scanout #(
    .H_VISIBLE(SH_VIS), .H_FRONT(SH_FP), .H_SYNC(SH_SY), .H_BACK(SH_BP),
    .V_VISIBLE(SV_VIS), .V_FRONT(SV_FP), .V_SYNC(SV_SY), .V_BACK(SV_BP),
    .BASE_ADDR(13'd0)
  ) dut_s (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n),
    .vaddr(vaddr_s), .vdata(vdata_s), .vbyte(vbyte_s),
    .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s),
    .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_BLANK_N(blank_n_s), .VGA_SYNC_N(sync_n_s),
    .VGA_CLK(vga_clk_s), .vblank(vblank_s), .frame_start(fs_s)
  );

  vga_scanout #(
    .BASE_ADDR(13'd1000)
  ) dut_d (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n),
    .vaddr(vaddr_d), .vdata(vdata_d), .vbyte(vbyte_d),
    .VGA_R(r_d), .VGA_G(g_d), .VGA_B(b_d),
    .VGA_HS(hs_d), .VGA_VS(vs_d), .VGA_BLANK_N(blank_n_d), .VGA_SYNC_N(sync_n_d),
    .VGA_CLK(vga_clk_d), .vblank(vblank_d), .frame_start(fs_d)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Synchronous RAM with one cycle of read latency, one port per instance.
  always @(posedge CLOCK_50) begin
    vdata_s <= mem[vaddr_s];
    vdata_d <= mem[vaddr_d];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 20)
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fb_byte(input int idx);
    logic [31:0] w;
    w = mem[idx / 4];
    return 8'(w >> (8 * (idx % 4)));
  endfunction

  // Widens a 3-bit channel arithmetically: c*32 + c*4 + c/2.
  function automatic logic [7:0] widen3(input int c);
    return 8'(c * 32 + c * 4 + c / 2);
  endfunction

  function automatic logic [23:0] expand(input logic [7:0] px);
    int rc, gc, bc;
    rc = int'(px) / 32;
    gc = (int'(px) / 4) % 8;
    bc = int'(px) % 4;
    return {widen3(rc), widen3(gc), 8'(bc * 85)};
  endfunction

  // Compares every output of both instances after n posedges since release.
  task automatic check_cycle(input int n);
    int p, q, hc, vc, h, v, idx, qidx, hd, vd, idx_d;
    bit vis, hs_e, vs_e, vbl_e, fs_e, hsd_e;
    logic [23:0] rgb_e;

    p   = n / 2;
    hc  = p % SH_TOT;
    vc  = (p / SH_TOT) % SV_TOT;
    idx = (vc / 4) * 160 + hc / 4;
    check("s_vaddr", 32'(vaddr_s), 32'(idx / 4));
    check("s_vbyte", 32'(vbyte_s), 32'(idx % 4));
    check("s_vga_clk", 32'(vga_clk_s), 32'(n % 2));
    check("s_sync_n", 32'(sync_n_s), 32'(0));

    if (n < 2) begin
      rgb_e = 24'h0; vis = 0; hs_e = 1; vs_e = 1; vbl_e = 0; fs_e = 0; hsd_e = 1;
    end else begin
      q     = p - 1;
      h     = q % SH_TOT;
      v     = (q / SH_TOT) % SV_TOT;
      vis   = (h < SH_VIS) && (v < SV_VIS);
      qidx  = (v / 4) * 160 + h / 4;
      rgb_e = vis ? expand(fb_byte(qidx)) : 24'h0;
      hs_e  = !((h >= 44) && (h <= 51));
      vs_e  = !((v >= 26) && (v <= 27));
      vbl_e = (v >= 24);
      fs_e  = (n % 2 == 0) && (q % S_FRAME == 0);
      hsd_e = !(((q % 800) >= 656) && ((q % 800) <= 751));
    end
    check("s_rgb", 32'({r_s, g_s, b_s}), 32'(rgb_e));
    check("s_blank_n", 32'(blank_n_s), 32'(vis));
    check("s_hs", 32'(hs_s), 32'(hs_e));
    check("s_vs", 32'(vs_s), 32'(vs_e));
    check("s_vblank", 32'(vblank_s), 32'(vbl_e));
    check("s_frame_start", 32'(fs_s), 32'(fs_e));

    // Default raster: addresses offset by 1000, horizontal sync.
    hd    = p % 800;
    vd    = (p / 800) % 525;
    idx_d = (vd / 4) * 160 + hd / 4;
    check("d_vaddr", 32'(vaddr_d), 32'((1000 + idx_d / 4) % 8192));
    check("d_vbyte", 32'(vbyte_d), 32'(idx_d % 4));
    check("d_hs", 32'(hs_d), 32'(hsd_e));
  endtask

  // Runs ncyc cycles after a reset release, with directed points and totals.
  task automatic run(input int ncyc, input bit run2);
    int win_end, hs_low, vs_low, blank_hi, vbl_hi, fs_cnt, viol;
    int hsd_low, bld_hi, hs_f0, hs_f1, vs_f0, vs_f1, hd_f0, hd_f1;
    logic hs_prev, vs_prev, hd_prev;

    win_end = run2 ? 2 * S_FRAME + 1 : 4 * S_FRAME + 1;
    hs_low = 0; vs_low = 0; blank_hi = 0; vbl_hi = 0; fs_cnt = 0; viol = 0;
    hsd_low = 0; bld_hi = 0;
    hs_f0 = -1; hs_f1 = -1; vs_f0 = -1; vs_f1 = -1; hd_f0 = -1; hd_f1 = -1;
    hs_prev = 1'b1; vs_prev = 1'b1; hd_prev = 1'b1;

    check_cycle(0);
    check("reset_hs", 32'(hs_s), 32'(1));
    check("reset_blank_n", 32'(blank_n_s), 32'(0));
    check("base1000_vaddr_0_0", 32'(vaddr_d), 32'(1000));

    for (int n = 1; n <= ncyc; n++) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      check_cycle(n);

      if (!run2) begin
        if (n == 3)    check("pix0_white", 32'({r_s, g_s, b_s}), 32'h00FF_FFFF);
        if (n == 11)   check("pix1_red",   32'({r_s, g_s, b_s}), 32'h00FF_0000);
        if (n == 19)   check("pix2_green", 32'({r_s, g_s, b_s}), 32'h0000_FF00);
        if (n == 27)   check("pix3_blue",  32'({r_s, g_s, b_s}), 32'h0000_00FF);
        if (n == 8)    check("addr_4_0",   32'({vaddr_s, vbyte_s}), 32'({13'd0, 2'd1}));
        if (n == 512)  check("addr_16_4",  32'({vaddr_s, vbyte_s}), 32'({13'd41, 2'd0}));
        if (n == 2838) check("addr_last_vis", 32'({vaddr_s, vbyte_s}), 32'({13'd202, 2'd1}));
        if (n == 6432) check("base1000_addr_16_4", 32'({vaddr_d, vbyte_d}), 32'({13'd1041, 2'd0}));
      end else begin
        if (n == 81) check("last_vis_px_rgb", 32'({blank_n_s, r_s, g_s, b_s}), 32'h01FF_FFFF);
        if (n == 82) check("first_blank_px",  32'({blank_n_s, r_s, g_s, b_s}), 32'h0000_0000);
      end

      if (n >= 2 && n <= win_end) begin
        hs_low   += int'(!hs_s);
        vs_low   += int'(!vs_s);
        blank_hi += int'(blank_n_s);
        vbl_hi   += int'(vblank_s);
      end
      if (n >= 2 && n <= 1601) begin
        hsd_low += int'(!hs_d);
        bld_hi  += int'(blank_n_d);
      end
      if (!blank_n_s && ({r_s, g_s, b_s} != 24'h0)) viol++;
      fs_cnt += int'(fs_s);

      if (hs_prev && !hs_s) begin if (hs_f0 < 0) hs_f0 = n; else if (hs_f1 < 0) hs_f1 = n; end
      if (vs_prev && !vs_s) begin if (vs_f0 < 0) vs_f0 = n; else if (vs_f1 < 0) vs_f1 = n; end
      if (hd_prev && !hs_d) begin if (hd_f0 < 0) hd_f0 = n; else if (hd_f1 < 0) hd_f1 = n; end
      hs_prev = hs_s; vs_prev = vs_s; hd_prev = hs_d;
    end

    check("blank_rgb_zero", 32'(viol), 32'(0));
    check("hs_first_fall", 32'(hs_f0), 32'(90));
    check("hs_period", 32'(hs_f1 - hs_f0), 32'(120));
    check("vs_first_fall", 32'(vs_f0), 32'(3122));
    check("d_hs_first_fall", 32'(hd_f0), 32'(1314));
    check("d_hs_period", 32'(hd_f1 - hd_f0), 32'(1600));
    check("d_hs_low_cycles", 32'(hsd_low), 32'(192));
    check("d_blank_hi_line0", 32'(bld_hi), 32'(1280));
    if (!run2) begin
      check("vs_period", 32'(vs_f1 - vs_f0), 32'(3840));
      check("hs_low_2frames", 32'(hs_low), 32'(1024));
      check("vs_low_2frames", 32'(vs_low), 32'(480));
      check("blank_hi_2frames", 32'(blank_hi), 32'(3840));
      check("vblank_hi_2frames", 32'(vbl_hi), 32'(1920));
      check("frame_start_pulses", 32'(fs_cnt), 32'(3));
    end else begin
      check("blank_hi_1frame", 32'(blank_hi), 32'(1920));
      check("vblank_hi_1frame", 32'(vbl_hi), 32'(960));
      check("frame_start_pulses_r2", 32'(fs_cnt), 32'(2));
    end
  endtask

  initial begin
    int idx, x, y;
    logic [7:0] bv;

    // Checkerboard of red and green framebuffer pixels. Word 0 holds the
    // colour-expansion test word.
    for (int w = 0; w < 8192; w++) begin
      for (int k = 0; k < 4; k++) begin
        idx = w * 4 + k;
        x   = idx % 160;
        y   = idx / 160;
        bv  = ((x + y) % 2 == 1) ? 8'hE0 : 8'h1C;
        mem[w][8*k +: 8] = bv;
      end
    end
    mem[0] = 32'h031C_E0FF;

    reset_n = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    #2 reset_n = 1'b1;
    run(7700, 1'b0);

    // Reset in the middle of a line. Every output returns to idle at once.
    #3 reset_n = 1'b0;
    #1;
    check("mid_reset_hs_vs", 32'({hs_s, vs_s}), 32'(2'b11));
    check("mid_reset_blank_n", 32'(blank_n_s), 32'(0));
    check("mid_reset_rgb", 32'({r_s, g_s, b_s}), 32'(0));
    check("mid_reset_vaddr_vbyte", 32'({vaddr_s, vbyte_s}), 32'(0));
    check("mid_reset_clk_vbl_fs", 32'({vga_clk_s, vblank_s, fs_s}), 32'(0));
    check("mid_reset_d_vaddr", 32'(vaddr_d), 32'(1000));

    // Fill the framebuffer with all 0xFF for the blanking run.
    for (int w = 0; w < 8192; w++) mem[w] = 32'hFFFF_FFFF;
    repeat (3) @(negedge CLOCK_50);
    #2 reset_n = 1'b1;
    run(3900, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
